idli_sqi_mem_m: RTL
===================

Name: idli_sqi_mem_m

Overview:
- Synthesizable SQI (quad-SPI) responder: the memory end of the link driven by the core's SQI controller.
- Models a small 23LC1024-style serial SRAM in quad mode: 8-bit command, 24-bit address, then auto-incrementing byte data.
- Used for on-chip boot/scratch RAM and as the synthesizable DUT partner in core-level benches.
- Runs on the same gck as the initiator; sck is treated as a sampled data signal, never as a clock.

Parameters:
- DEPTH, 64, memory size in bytes; must be a power of two, at least 2.
- AW, $clog2(DEPTH), derived internal address width; do not override.

Ports:
- i_mem_gck  in  1  global clock
- i_mem_rst_n  in  1  reset; see Behaviour
- i_mem_sqi_sck  in  1  serial clock from initiator
- i_mem_sqi_cs  in  1  chip select, active low
- i_mem_sqi_mode  in  1  initiator direction, package type sqi_mode_t; SQI_MODE_IN means the initiator is receiving
- i_mem_sqi_data  in  4  nibble driven by initiator
- o_mem_sqi_data  out  4  nibble driven by responder
- o_mem_sqi_oe  out  1  responder drive enable
- o_mem_err  out  1  sticky unknown-command flag; cleared by reset only

Interface decision:
- One clock; reset is synchronous and active-low (i_mem_gck, i_mem_rst_n).

Behaviour:
- Edge detect:
  - sck_q is sck registered once on gck.
  - rise = sck & ~sck_q; fall = ~sck & sck_q.
  - All protocol events qualify on rise or fall with cs low.
- Nibble order: high nibble first for command, address (MSB first) and data.
- FSM states: IDLE, CMD, ADDR, DUMMY, RD, WR, IGN.
  - IDLE -> CMD: cs low, on the same cycle.
  - CMD: collects 2 nibbles on rise.
    - 0x03 -> ADDR (read); 0x02 -> ADDR (write).
    - Any other value -> IGN and set o_mem_err.
  - ADDR: collects 6 nibbles; only addr[AW-1:0] is kept, upper bits are ignored.
    - Read -> DUMMY; write -> WR.
  - DUMMY: 2 rise events, input ignored, then -> RD.
  - RD: data is updated on fall, so it is stable for the initiator's sampling rise.
    - First nibble is presented in the cycle after entry to RD.
    - After the low nibble of a byte is consumed (rise), addr increments.
  - WR: nibble pairs assemble a byte; the byte is committed to mem[addr] on the rise of its low nibble, then addr increments.
  - IGN: no response until cs high.
  - Any state, cs high: next state IDLE. A partially received write byte is discarded; memory is unchanged.
- Address wrap: addr increments modulo DEPTH (DEPTH-1 -> 0) in both RD and WR.
- o_mem_sqi_oe = (state == RD) & ~cs & (mode == SQI_MODE_IN). It is a registered output, one-cycle latency.
- o_mem_sqi_data is 0 whenever oe is 0.
- Reset (synchronous, active-low, any state including mid-transfer):
  - Values after the reset edge: state IDLE, o_mem_sqi_data 0, o_mem_sqi_oe 0, o_mem_err 0, addr 0, nibble counter 0.
  - Memory array is not reset.
- Simultaneous events:
  - Reset has priority over cs.
  - cs high has priority over rise or fall in the same cycle.
  - Backdoor write has priority over an SQI write to the same address in the same cycle.

Optional Feature:
- Macro: IDLI_SQI_MEM_BACKDOOR_EN.
- Defined: adds ports i_mem_bd_we (1), i_mem_bd_addr (AW), i_mem_bd_data (8), o_mem_bd_data (8).
  - Backdoor write is synchronous.
  - o_mem_bd_data = mem[i_mem_bd_addr], combinational read.
  - Used for preload and checking.
- Undefined: these ports are absent; memory is reachable only via SQI.

Decomposition:
- Package idli_pkg supplies:
  - sqi_mode_t and SQI_MODE_IN / SQI_MODE_OUT (already shared);
  - new enum sqi_mem_state_t;
  - constants SQI_CMD_READ = 8'h03, SQI_CMD_WRITE = 8'h02, SQI_ADDR_NIBBLES = 6, SQI_DUMMY_NIBBLES = 2.
- One natural sub-module: idli_sqi_mem_array_m, a DEPTH x 8 register array with one write port and two combinational read ports (SQI and backdoor).
- FSM and shift logic stay in the top module.

Test Plan:
- Write then read back: cmd 0x02, addr 0x000010, data 0xA5, 0x3C, cs high. Then cmd 0x03, addr 0x000010, 2 dummy nibbles, 4 read nibbles -> A, 5, 3, C. oe is high only during RD with mode = SQI_MODE_IN.
- Wrap: write 0x11, 0x22 starting at addr DEPTH-1 -> mem[63] = 0x11, mem[0] = 0x22. A read from 63 returns 1, 1, 2, 2.
- Aborted write: cmd 0x02, addr 0x20, one nibble 0x7, then cs high -> mem[0x20] unchanged. The next transaction decodes normally.
- Unknown command 0xFF -> IGN, o_mem_err = 1, oe stays 0 through 10 further sck pulses. After cs high, a normal read works and o_mem_err stays 1.
- Reset mid-read (rst_n low for one cycle while oe = 1) -> oe = 0 and o_mem_sqi_data = 0 after the reset edge, o_mem_err = 0. The following read is correct.
- With IDLI_SQI_MEM_BACKDOOR_EN defined: backdoor-write 0x5A to addr 3, SQI read at addr 3 -> 5, A. SQI write 0xC3 to addr 4 -> o_mem_bd_data = 0xC3 at bd_addr 4.

Source files
------------

// File: rtl/idli_pkg.sv
// Shared SQI types and constants for the idli core and its SQI memory responder.
package idli_pkg;

    typedef enum logic {
        SQI_MODE_OUT = 1'b0,
        SQI_MODE_IN  = 1'b1
    } sqi_mode_t;

    typedef enum logic [2:0] {
        SQI_MEM_IDLE  = 3'd0,
        SQI_MEM_CMD   = 3'd1,
        SQI_MEM_ADDR  = 3'd2,
        SQI_MEM_DUMMY = 3'd3,
        SQI_MEM_RD    = 3'd4,
        SQI_MEM_WR    = 3'd5,
        SQI_MEM_IGN   = 3'd6
    } sqi_mem_state_t;

    localparam logic [7:0] SQI_CMD_READ      = 8'h03;
    localparam logic [7:0] SQI_CMD_WRITE     = 8'h02;
    localparam int         SQI_ADDR_NIBBLES  = 6;
    localparam int         SQI_DUMMY_NIBBLES = 2;

    // High nibble goes out first on the wire.
    function automatic logic [3:0] sqi_nibble(input logic [7:0] b, input logic lo);
        return lo ? b[3:0] : b[7:4];
    endfunction

endpackage

// File: rtl/idli_sqi_mem_array_m.sv
// DEPTH x 8 register array: one synchronous write port, combinational reads.
// The second (backdoor) read port exists only with IDLI_SQI_MEM_BACKDOOR_EN.
module idli_sqi_mem_array_m
    import idli_pkg::*;
#(
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
`ifdef IDLI_SQI_MEM_BACKDOOR_EN
    ,
    input  logic [AW-1:0] i_bd_raddr,
    output logic [7:0]    o_bd_rdata
`endif
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

`ifdef IDLI_SQI_MEM_BACKDOOR_EN
    assign o_bd_rdata = mem_q[i_bd_raddr];
`endif

endmodule

// File: rtl/idli_sqi_mem_m.sv
// Quad-SPI serial SRAM responder (23LC1024-style: cmd, 24-bit addr, byte data).
// Define IDLI_SQI_MEM_BACKDOOR_EN to add a backdoor preload/inspect port.
module idli_sqi_mem_m
    import idli_pkg::*;
#(
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          i_mem_gck,
    input  logic          i_mem_rst_n,
    input  logic          i_mem_sqi_sck,
    input  logic          i_mem_sqi_cs,
    input  sqi_mode_t     i_mem_sqi_mode,
    input  logic [3:0]    i_mem_sqi_data,
    output logic [3:0]    o_mem_sqi_data,
    output logic          o_mem_sqi_oe,
    output logic          o_mem_err
`ifdef IDLI_SQI_MEM_BACKDOOR_EN
    ,
    input  logic          i_mem_bd_we,
    input  logic [AW-1:0] i_mem_bd_addr,
    input  logic [7:0]    i_mem_bd_data,
    output logic [7:0]    o_mem_bd_data
`endif
);

    sqi_mem_state_t state_q, state_d;
    logic           sck_q;
    logic [2:0]     cnt_q, cnt_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [3:0]     nib_q, nib_d;
    logic           is_rd_q, is_rd_d;
    logic           err_q, err_d;
    logic           oe_q, oe_d;
    logic [3:0]     dout_q, dout_d;

    logic           rise, fall;
    logic           sqi_we;
    logic [7:0]     sqi_wdata;
    logic [7:0]     rd_byte;
    logic           mem_we;
    logic [AW-1:0]  mem_waddr;
    logic [7:0]     mem_wdata;

    assign rise = i_mem_sqi_sck & ~sck_q;
    assign fall = ~i_mem_sqi_sck & sck_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        nib_d     = nib_q;
        is_rd_d   = is_rd_q;
        err_d     = err_q;
        oe_d      = 1'b0;
        dout_d    = 4'h0;
        sqi_we    = 1'b0;
        sqi_wdata = {nib_q, i_mem_sqi_data};

        if (i_mem_sqi_cs) begin
            state_d = SQI_MEM_IDLE;
            cnt_d   = 3'd0;
        end else begin
            case (state_q)
                SQI_MEM_IDLE: begin
                    state_d = SQI_MEM_CMD;
                    cnt_d   = 3'd0;
                end
                SQI_MEM_CMD: begin
                    if (rise) begin
                        if (cnt_q[0] == 1'b0) begin
                            nib_d = i_mem_sqi_data;
                            cnt_d = 3'd1;
                        end else begin
                            cnt_d = 3'd0;
                            case ({nib_q, i_mem_sqi_data})
                                SQI_CMD_READ: begin
                                    state_d = SQI_MEM_ADDR;
                                    is_rd_d = 1'b1;
                                end
                                SQI_CMD_WRITE: begin
                                    state_d = SQI_MEM_ADDR;
                                    is_rd_d = 1'b0;
                                end
                                default: begin
                                    state_d = SQI_MEM_IGN;
                                    err_d   = 1'b1;
                                end
                            endcase
                        end
                    end
                end
                SQI_MEM_ADDR: begin
                    if (rise) begin
                        // Upper address bits simply shift out of the top.
                        addr_d = AW'({addr_q, i_mem_sqi_data});
                        if (cnt_q == 3'(SQI_ADDR_NIBBLES - 1)) begin
                            cnt_d   = 3'd0;
                            state_d = is_rd_q ? SQI_MEM_DUMMY : SQI_MEM_WR;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                SQI_MEM_DUMMY: begin
                    if (rise) begin
                        if (cnt_q == 3'(SQI_DUMMY_NIBBLES - 1)) begin
                            cnt_d   = 3'd0;
                            state_d = SQI_MEM_RD;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                SQI_MEM_RD: begin
                    if (rise) begin
                        cnt_d = {2'b00, ~cnt_q[0]};
                        if (cnt_q[0]) begin
                            addr_d = addr_q + AW'(1);
                        end
                    end
                    oe_d = (i_mem_sqi_mode == SQI_MODE_IN);
                    // Reload on fall (or when drive starts) so the nibble is settled by the next rise.
                    if (oe_d) begin
                        dout_d = (!oe_q || fall) ? sqi_nibble(rd_byte, cnt_q[0]) : dout_q;
                    end
                end
                SQI_MEM_WR: begin
                    if (rise) begin
                        if (cnt_q[0] == 1'b0) begin
                            nib_d = i_mem_sqi_data;
                            cnt_d = 3'd1;
                        end else begin
                            sqi_we = 1'b1;
                            addr_d = addr_q + AW'(1);
                            cnt_d  = 3'd0;
                        end
                    end
                end
                SQI_MEM_IGN: begin
                    state_d = SQI_MEM_IGN;
                end
                default: begin
                    state_d = SQI_MEM_IDLE;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge i_mem_gck) begin
        if (!i_mem_rst_n) begin
            state_q <= SQI_MEM_IDLE;
            sck_q   <= 1'b0;
            cnt_q   <= 3'd0;
            addr_q  <= '0;
            nib_q   <= 4'h0;
            is_rd_q <= 1'b0;
            err_q   <= 1'b0;
            oe_q    <= 1'b0;
            dout_q  <= 4'h0;
        end else begin
            state_q <= state_d;
            sck_q   <= i_mem_sqi_sck;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            nib_q   <= nib_d;
            is_rd_q <= is_rd_d;
            err_q   <= err_d;
            oe_q    <= oe_d;
            dout_q  <= dout_d;
        end
    end

`ifdef IDLI_SQI_MEM_BACKDOOR_EN
    // The backdoor owns the shared write port whenever it writes.
    assign mem_we    = i_mem_bd_we | sqi_we;
    assign mem_waddr = i_mem_bd_we ? i_mem_bd_addr : addr_q;
    assign mem_wdata = i_mem_bd_we ? i_mem_bd_data : sqi_wdata;
`else
    assign mem_we    = sqi_we;
    assign mem_waddr = addr_q;
    assign mem_wdata = sqi_wdata;
`endif

    idli_sqi_mem_array_m #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk        (i_mem_gck),
        .i_we       (mem_we),
        .i_waddr    (mem_waddr),
        .i_wdata    (mem_wdata),
        .i_raddr    (addr_q),
        .o_rdata    (rd_byte)
`ifdef IDLI_SQI_MEM_BACKDOOR_EN
        ,
        .i_bd_raddr (i_mem_bd_addr),
        .o_bd_rdata (o_mem_bd_data)
`endif
    );

    assign o_mem_sqi_data = dout_q;
    assign o_mem_sqi_oe   = oe_q;
    assign o_mem_err      = err_q;

endmodule
